// File: rtl/miriscv_imem_responder.sv
// Instruction-fetch responder with an internal word-array memory.
// A level-held fetch request is accepted in IDLE, held for a programmable
// number of cycles, and answered with a single-cycle rvalid pulse. A
// write-only load port fills the memory for boot code or bench preload.
module miriscv_imem_responder #(
  parameter int unsigned     XLEN          = 32,
  parameter int unsigned     DEPTH         = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR     = '0,
  parameter int unsigned     LATENCY       = 1,
  parameter logic [XLEN-1:0] ILLEGAL_INSTR = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            instr_req_i,
  input  logic [XLEN-1:0] instr_addr_i,
  output logic            instr_rvalid_o,
  output logic [XLEN-1:0] instr_rdata_o,
  output logic            instr_err_o,
  input  logic            load_we_i,
  input  logic [XLEN-1:0] load_addr_i,
  input  logic [XLEN-1:0] load_wdata_i,
  output logic            busy_o
);

  localparam int unsigned     AW        = $clog2(DEPTH);
  localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(DEPTH * 4);
  localparam logic [3:0]      LAT_INIT  = 4'(LATENCY - 1);
  localparam bit              SINGLE    = (LATENCY == 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [3:0]      counter;
  logic [3:0]      counter_next;
  logic [XLEN-1:0] addr_q;
  logic            capture;

  logic [XLEN-1:0] mem [DEPTH];

  logic [XLEN-1:0] fetch_addr;
  logic [XLEN-1:0] fetch_off;
  logic            fetch_err;
  logic [AW-1:0]   fetch_index;
  logic            enter_resp;

  logic [XLEN-1:0] load_off;
  logic            load_hit;
  logic [AW-1:0]   load_index;

  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  // State, latency counter and captured address; reset aborts any pending fetch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      counter <= '0;
      addr_q  <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      if (capture) begin
        addr_q <= instr_addr_i;
      end
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT (abort if the request drops), pulse in RESP.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    capture      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (instr_req_i) begin
          capture      = 1'b1;
          counter_next = LAT_INIT;
          state_next   = SINGLE ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        counter_next = counter - 4'd1;
        if (!instr_req_i) begin
          state_next = ST_IDLE;
        end else if (counter == 4'd1) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Address decode for the fetch being answered. With single-cycle latency the
  // response is built on the accepting edge, before addr_q holds the address,
  // so IDLE decodes the live request address instead.
  always_comb begin
    fetch_addr  = (state == ST_IDLE) ? instr_addr_i : addr_q;
    fetch_off   = fetch_addr - BASE_ADDR;
    fetch_err   = (fetch_addr[1:0] != 2'b00) || (fetch_off >= MEM_BYTES);
    fetch_index = fetch_off[AW+1:2];
    enter_resp  = (state_next == ST_RESP);
  end

  // Load-port decode; the low two address bits select nothing, so misaligned writes land on the containing word.
  always_comb begin
    load_off   = load_addr_i - BASE_ADDR;
    load_hit   = load_we_i && (load_off < MEM_BYTES);
    load_index = load_off[AW+1:2];
  end

  // Memory write port, independent of the FSM and of reset so preload survives a reset pulse.
  always_ff @(posedge clk_i) begin
    if (load_hit) begin
      mem[load_index] <= load_wdata_i;
    end
  end

  // Response registers: loaded on the edge entering RESP (memory read sees pre-write data), zero otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      err_q   <= fetch_err;
      rdata_q <= fetch_err ? ILLEGAL_INSTR : mem[fetch_index];
    end else begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  assign instr_rvalid_o = (state == ST_RESP);
  assign instr_rdata_o  = rdata_q;
  assign instr_err_o    = err_q;
  assign busy_o         = (state != ST_IDLE);

endmodule

// File: tb/tb_miriscv_imem_responder.sv
// Directed bench for miriscv_imem_responder. Three instances cover
// single-cycle latency, latency 4 and latency 3 with a non-zero base address.
module tb_miriscv_imem_responder;

  logic        clk;
  logic        rst;
  logic        req        [3];
  logic [31:0] addr       [3];
  logic        rvalid     [3];
  logic [31:0] rdata      [3];
  logic        err        [3];
  logic        load_we    [3];
  logic [31:0] load_addr  [3];
  logic [31:0] load_wdata [3];
  logic        busy       [3];

  int checks;
  int failures;
  int cyc;

  localparam logic [31:0] ILL0 = 32'h0010_0073;
  localparam logic [31:0] ILL2 = 32'h0000_0001;

  miriscv_imem_responder #(
    .XLEN(32), .DEPTH(1024), .BASE_ADDR(32'h0), .LATENCY(1), .ILLEGAL_INSTR(ILL0)
  ) u_lat1 (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(req[0]), .instr_addr_i(addr[0]),
    .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]), .instr_err_o(err[0]),
    .load_we_i(load_we[0]), .load_addr_i(load_addr[0]), .load_wdata_i(load_wdata[0]),
    .busy_o(busy[0])
  );

  miriscv_imem_responder #(
    .XLEN(32), .DEPTH(1024), .BASE_ADDR(32'h0), .LATENCY(4), .ILLEGAL_INSTR(32'h0)
  ) u_lat4 (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(req[1]), .instr_addr_i(addr[1]),
    .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]), .instr_err_o(err[1]),
    .load_we_i(load_we[1]), .load_addr_i(load_addr[1]), .load_wdata_i(load_wdata[1]),
    .busy_o(busy[1])
  );

  miriscv_imem_responder #(
    .XLEN(32), .DEPTH(16), .BASE_ADDR(32'h8000_0000), .LATENCY(3), .ILLEGAL_INSTR(ILL2)
  ) u_lat3 (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(req[2]), .instr_addr_i(addr[2]),
    .instr_rvalid_o(rvalid[2]), .instr_rdata_o(rdata[2]), .instr_err_o(err[2]),
    .load_we_i(load_we[2]), .load_addr_i(load_addr[2]), .load_wdata_i(load_wdata[2]),
    .busy_o(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input int d, input logic r, input logic [31:0] a);
    req[d]  = r;
    addr[d] = a;
  endtask

  task automatic preload(input int d, input logic [31:0] a, input logic [31:0] data);
    load_we[d]    = 1'b1;
    load_addr[d]  = a;
    load_wdata[d] = data;
    tick();
    load_we[d]    = 1'b0;
  endtask

  // Hold a request until rvalid (bounded), check latency/data/err, then check outputs clear.
  task automatic fetch(input int d, input logic [31:0] a, input logic [31:0] exp_data,
                       input logic exp_err, input int exp_lat, input string tag);
    int k;
    k = 0;
    applyStimulus(d, 1'b1, a);
    do begin
      tick();
      k++;
    end while (!rvalid[d] && k < 40);
    applyStimulus(d, 1'b0, a);
    checkOutput({tag, "_lat"}, k, exp_lat);
    checkOutput({tag, "_data"}, rdata[d], exp_data);
    checkOutput({tag, "_err"}, {31'b0, err[d]}, {31'b0, exp_err});
    tick();
    checkOutput({tag, "_clr"}, {rvalid[d], err[d], rdata[d][29:0]}, 32'h0);
  endtask

  initial begin
    int n;
    int last;
    int guard;
    logic seen;

    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst      = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0; addr[d] = '0;
      load_we[d] = 1'b0; load_addr[d] = '0; load_wdata[d] = '0;
    end
    tick();
    tick();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset_ctl%0d", d), {29'b0, rvalid[d], err[d], busy[d]}, 32'h0);
      checkOutput($sformatf("reset_rdata%0d", d), rdata[d], 32'h0);
    end

    // Test 1: single-cycle latency basic fetch.
    preload(0, 32'h0000_000C, 32'h0000_0013);
    tick();
    fetch(0, 32'h0000_000C, 32'h0000_0013, 1'b0, 1, "t1");

    // Test 3: misaligned, one past the end, and the last valid word.
    fetch(0, 32'h0000_0002, ILL0, 1'b1, 1, "t3_mis");
    fetch(0, 32'h0000_1000, ILL0, 1'b1, 1, "t3_oor");
    preload(0, 32'h0000_0FFC, 32'h1234_5678);
    fetch(0, 32'h0000_0FFC, 32'h1234_5678, 1'b0, 1, "t3_last");

    // Test 5: load to the word being read on the RESP-entry edge returns old data.
    preload(0, 32'h0000_0014, 32'h0050_0513);
    applyStimulus(0, 1'b1, 32'h0000_0014);
    load_we[0]    = 1'b1;
    load_addr[0]  = 32'h0000_0014;
    load_wdata[0] = 32'hDEAD_BEEF;
    tick();
    load_we[0] = 1'b0;
    applyStimulus(0, 1'b0, 32'h0000_0014);
    checkOutput("t5_rvalid", {31'b0, rvalid[0]}, 32'h1);
    checkOutput("t5_old", rdata[0], 32'h0050_0513);
    tick();
    fetch(0, 32'h0000_0014, 32'hDEAD_BEEF, 1'b0, 1, "t5_new");

    // Test 2: latency 4, then a request dropped mid-wait.
    preload(1, 32'h0000_0010, 32'h0040_0093);
    fetch(1, 32'h0000_0010, 32'h0040_0093, 1'b0, 4, "t2");
    applyStimulus(1, 1'b1, 32'h0000_0010);
    tick();
    checkOutput("t2_busy", {31'b0, busy[1]}, 32'h1);
    tick();
    applyStimulus(1, 1'b0, 32'h0000_0010);
    tick();
    checkOutput("t2_abort_busy", {31'b0, busy[1]}, 32'h0);
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (rvalid[1] || busy[1]) seen = 1'b1;
    end
    checkOutput("t2_no_rvalid", {31'b0, seen}, 32'h0);

    // Test 4: eight streamed fetches, request re-presented right after each rvalid.
    for (int i = 0; i < 8; i++) begin
      preload(1, 32'(i * 4), 32'h1000_0000 + 32'(i) * 32'h0101);
    end
    n     = 0;
    guard = 0;
    applyStimulus(1, 1'b1, 32'h0);
    last = cyc;
    while (n < 8 && guard < 100) begin
      tick();
      guard++;
      if (rvalid[1]) begin
        checkOutput($sformatf("t4_data%0d", n), rdata[1], 32'h1000_0000 + 32'(n) * 32'h0101);
        checkOutput($sformatf("t4_gap%0d", n), cyc - last, (n == 0) ? 4 : 5);
        last = cyc;
        n++;
        if (n < 8) applyStimulus(1, 1'b1, 32'(n * 4));
        else       applyStimulus(1, 1'b0, 32'h0);
      end
    end
    checkOutput("t4_count", n, 8);
    applyStimulus(1, 1'b0, 32'h0);
    tick();

    // Test 6: reset during WAIT aborts; memory and reset-time loads survive.
    preload(2, 32'h8000_0008, 32'hCAFE_0001);
    applyStimulus(2, 1'b1, 32'h8000_0008);
    tick();
    checkOutput("t6_busy", {31'b0, busy[2]}, 32'h1);
    tick();
    rst           = 1'b1;
    applyStimulus(2, 1'b0, 32'h8000_0008);
    load_we[2]    = 1'b1;
    load_addr[2]  = 32'h8000_000C;
    load_wdata[2] = 32'h0000_0C0C;
    tick();
    rst        = 1'b0;
    load_we[2] = 1'b0;
    checkOutput("t6_rst_ctl", {29'b0, rvalid[2], err[2], busy[2]}, 32'h0);
    checkOutput("t6_rst_rdata", rdata[2], 32'h0);
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (rvalid[2]) seen = 1'b1;
    end
    checkOutput("t6_no_rvalid", {31'b0, seen}, 32'h0);
    fetch(2, 32'h8000_0008, 32'hCAFE_0001, 1'b0, 3, "t6_intact");
    fetch(2, 32'h8000_000C, 32'h0000_0C0C, 1'b0, 3, "t6_rstload");
    preload(2, 32'h8000_0007, 32'h7777_0004);
    fetch(2, 32'h8000_0004, 32'h7777_0004, 1'b0, 3, "t6_misload");
    fetch(2, 32'h8000_0040, ILL2, 1'b1, 3, "t6_oor_hi");
    fetch(2, 32'h7FFF_FFFC, ILL2, 1'b1, 3, "t6_oor_lo");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
